// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - whb size encodings used by both loads and stores
//   - lsu_state_t: access-sequencing states
//   - lsu_bad_access(): flags illegal sizes and misaligned addresses
package lsu_pkg;

  localparam logic [2:0] WHB_B  = 3'd0;  // lb / sb
  localparam logic [2:0] WHB_H  = 3'd1;  // lh / sh
  localparam logic [2:0] WHB_W  = 3'd2;  // lw / sw
  localparam logic [2:0] WHB_BU = 3'd3;  // lbu
  localparam logic [2:0] WHB_HU = 3'd4;  // lhu

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  // Stores only know b/h/w, loads additionally bu/hu.
  function automatic logic lsu_bad_access(input logic       is_store,
                                          input logic [2:0] whb,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (is_store && (whb > WHB_W)) begin
      bad = 1'b1;
    end else if (!is_store && (whb > WHB_HU)) begin
      bad = 1'b1;
    end else if (((whb == WHB_H) || (whb == WHB_HU)) && addr_lo[0]) begin
      bad = 1'b1;
    end else if ((whb == WHB_W) && (addr_lo != 2'b00)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   i_lane   in  2   byte offset within the word (addr[1:0])
//   i_whb    in  3   access size code
//   i_wdata  in  32  raw store data (rs2)
//   i_rdata  in  32  raw word read from the bus
//   o_be     out 4   byte enables for the selected lane(s)
//   o_wdata  out 32  store data replicated across all lanes
//   o_rdata  out 32  selected lane, sign- or zero-extended
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_whb,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_whb)
      WHB_B: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      WHB_BU: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h000000, w_byte};
      end
      WHB_H: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      WHB_HU: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0000, w_half};
      end
      WHB_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Accepts one load or store from the pipeline,
// runs it over a word-addressed request/grant/response bus and stalls the
// pipeline until the access completes.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   op_valid, MemRW, whb,    memory-stage access (held while stall=1)
//   addr, wdata
//   stall                    freezes PC and pipeline registers
//   done, lsu_err            completion pulse and its error flag
//   load_data                extended load result, valid with done
//   dmem_req/we/addr/be/wdata  bus request side
//   dmem_gnt, dmem_rvalid, dmem_rdata  bus grant and read response
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              MemRW,
  input  logic [2:0]        whb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              lsu_err,
  output logic [31:0]       load_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t r_state;
  lsu_state_t w_next_state;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic [2:0]        r_whb;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_load_data;

  logic        w_bad;
  logic        w_accept;
  logic        w_reject;
  logic        w_capture;
  logic        w_req;
  logic        w_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_bad = lsu_bad_access(MemRW, whb, addr[1:0]);

  // The aligner works purely on the captured fields so bus outputs and the
  // load extension cannot move while the pipeline is holding its inputs.
  lsu_lane_align u_align (
    .i_lane  (r_lane),
    .i_whb   (r_whb),
    .i_wdata (r_wdata),
    .i_rdata (dmem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_rep),
    .o_rdata (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;
    w_req        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (w_bad) begin
            w_reject     = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_accept     = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_req = 1'b1;
        if (dmem_gnt) begin
          w_next_state = r_we ? S_DONE : S_RESP;
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_lane      <= 2'b00;
      r_whb       <= 3'd0;
      r_we        <= 1'b0;
      r_wdata     <= 32'h0;
      r_err       <= 1'b0;
      r_load_data <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_lane  <= addr[1:0];
        r_whb   <= whb;
        r_we    <= MemRW;
        r_wdata <= wdata;
        r_err   <= 1'b0;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      if (w_capture) begin
        r_load_data <= w_rdata_ext;
      end
    end
  end

  // Stall is combinational so the pipeline freezes in the acceptance cycle;
  // it drops in DONE so the pipeline advances at the end of that cycle.
  assign stall      = op_valid & (r_state != S_DONE);
  assign done       = w_done;
  assign lsu_err    = w_done & r_err;
  assign load_data  = r_load_data;
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & r_we;
  assign dmem_addr  = r_addr;
  // Lane mask is only presented while a request is on the bus.
  assign dmem_be    = w_req ? w_be : 4'b0000;
  assign dmem_wdata = w_wdata_rep;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        MemRW;
  logic [2:0]  whb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        lsu_err;
  logic [31:0] load_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        is_load;
  } sb_item_t;

  sb_item_t sb_q[$];

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .MemRW       (MemRW),
    .whb         (whb),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .lsu_err     (lsu_err),
    .load_data   (load_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after done,
  // leaving op_valid asserted so a following access can start immediately.
  task automatic run_op(input string name, input logic we_i, input logic [2:0] whb_i,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rvd, input logic [31:0] rd,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] eload, input logic eerr);
    sb_item_t it;
    sb_item_t got;
    int reqs;
    int since;
    int exp_done;
    bit granted;
    bit finished;
    it.data    = eload;
    it.err     = eerr;
    it.is_load = !we_i;
    sb_q.push_back(it);
    exp_done = eerr ? 1 : (we_i ? gd + 2 : gd + rvd + 2);
    op_valid   = 1'b1;
    MemRW      = we_i;
    whb        = whb_i;
    addr       = a;
    wdata      = wd;
    dmem_rdata = rd;
    reqs = 0;
    since = 0;
    granted = 0;
    finished = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      if (c == 0) chk({name, ".accept_req"}, {31'b0, dmem_req}, 32'd0);
      if (done) begin
        chk({name, ".done_cycle"}, c, exp_done);
        chk({name, ".done_stall"}, {31'b0, stall}, 32'd0);
        chk({name, ".done_req"}, {31'b0, dmem_req}, 32'd0);
        if (sb_q.size() == 0) begin
          chk({name, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
          got = sb_q.pop_front();
          chk({name, ".lsu_err"}, {31'b0, lsu_err}, {31'b0, got.err});
          if (got.is_load && !got.err) chk({name, ".load_data"}, load_data, got.data);
        end
        $display("txn %s: done at cycle %0d err=%0b load_data=0x%08h", name, c, lsu_err, load_data);
        finished = 1;
      end else begin
        chk({name, ".stall"}, {31'b0, stall}, 32'd1);
        if (dmem_req) begin
          chk({name, ".req_err"}, {31'b0, eerr}, 32'd0);
          chk({name, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
          chk({name, ".be"}, {28'b0, dmem_be}, {28'b0, ebe});
          chk({name, ".we"}, {31'b0, dmem_we}, {31'b0, we_i});
          if (we_i) chk({name, ".wdata"}, dmem_wdata, ewd);
          if (reqs == gd) begin
            dmem_gnt = 1'b1;
            granted = 1;
          end
          reqs++;
        end else if (granted) begin
          since++;
          if (since == rvd) dmem_rvalid = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
    end
    if (!finished) chk({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_cycle(input string name);
    op_valid = 1'b0;
    #1;
    chk({name, ".idle_done"}, {31'b0, done}, 32'd0);
    chk({name, ".idle_stall"}, {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; MemRW = 1'b0; whb = 3'd0; addr = 32'h0; wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", {31'b0, stall}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.lsu_err", {31'b0, lsu_err}, 32'd0);
    chk("rst.req", {31'b0, dmem_req}, 32'd0);
    chk("rst.we", {31'b0, dmem_we}, 32'd0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.addr", dmem_addr, 32'h0);
    chk("rst.be", {28'b0, dmem_be}, 32'h0);
    chk("rst.wdata", dmem_wdata, 32'h0);
    $display("txn reset: outputs checked");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("sb",  1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 0, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
    idle_cycle("sb");
    run_op("lb",  1'b0, 3'd0, 32'h2001, 32'h0, 2, 1, 32'h0000_8000, 4'b0010, 32'h0, 32'hFFFF_FF80, 1'b0);
    idle_cycle("lb");
    run_op("lbu", 1'b0, 3'd3, 32'h2001, 32'h0, 0, 1, 32'h0000_8000, 4'b0010, 32'h0, 32'h0000_0080, 1'b0);
    idle_cycle("lbu");
    run_op("lhu", 1'b0, 3'd4, 32'h2002, 32'h0, 0, 1, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0000_BEEF, 1'b0);
    idle_cycle("lhu");
    run_op("lh",  1'b0, 3'd1, 32'h2002, 32'h0, 1, 3, 32'hBEEF_0000, 4'b1100, 32'h0, 32'hFFFF_BEEF, 1'b0);
    idle_cycle("lh");
    run_op("sw_mis", 1'b1, 3'd2, 32'h3002, 32'h1111_2222, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    idle_cycle("sw_mis");
    run_op("ld_whb5", 1'b0, 3'd5, 32'h3000, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    idle_cycle("ld_whb5");
    run_op("sh", 1'b1, 3'd1, 32'h5002, 32'h0000_CAFE, 1, 0, 32'h0, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0);
    idle_cycle("sh");
    run_op("lh_mis", 1'b0, 3'd1, 32'h5001, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
    idle_cycle("lh_mis");

    // back-to-back store then load of the same word; the load's accept cycle
    // is the single idle cycle between them
    run_op("b2b_sw", 1'b1, 3'd2, 32'h4000, 32'h1234_5678, 0, 0, 32'h0, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
    run_op("b2b_lw", 1'b0, 3'd2, 32'h4000, 32'h0, 0, 2, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);
    idle_cycle("b2b");

    // reset while waiting for read data
    op_valid = 1'b1; MemRW = 1'b0; whb = 3'd2; addr = 32'h6000; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstmid.accept_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("rstmid.req", {31'b0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("rstmid.resp_req", {31'b0, dmem_req}, 32'd0);
    chk("rstmid.resp_stall", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op_valid = 1'b0;
    dmem_rvalid = 1'b1;
    #1;
    chk("rstmid.after_req", {31'b0, dmem_req}, 32'd0);
    chk("rstmid.after_stall", {31'b0, stall}, 32'd0);
    chk("rstmid.after_done", {31'b0, done}, 32'd0);
    chk("rstmid.after_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    #1;
    chk("rstmid.stray_done", {31'b0, done}, 32'd0);
    chk("rstmid.stray_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid.stray_done2", {31'b0, done}, 32'd0);
    chk("rstmid.stray_load_data", load_data, 32'h0);
    $display("txn rst_mid: reset during RESP checked");

    chk("sb.drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
